// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - requester-side request/response bus of the SRAM arbiter
// Requesters drive the master modport; the arbiter sits on the slave modport.
interface sram_arbiter_if #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 11
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ-1:0]    req_we;
    logic [NREQ-1:0]    req_sel;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    rsp_valid;
    logic [2*DW-1:0]    rsp_rdata;
    logic               busy;

    modport master (
        output req_valid, req_we, req_sel, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, busy
    );

    modport slave (
        input  req_valid, req_we, req_sel, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, busy
    );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - round-robin arbiter sharing one dual-half SRAM between NREQ requesters
// One access per cycle; reads are tracked through a two-stage id pipeline back to their owner.
module sram_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int AW   = 11
) (
    input  logic            clk,
    input  logic            rst,
    sram_arbiter_if.slave   bus,
    output logic            sram_cen,
    output logic            sram_wen,
    output logic            sram_sel,
    output logic [AW-1:0]   sram_addr,
    output logic [DW-1:0]   sram_din,
    input  logic [2*DW-1:0] sram_dout
);
    localparam int IW = $clog2(NREQ);

    // (base + off) mod NREQ; base < NREQ and off < NREQ, so one subtraction suffices
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] base, input int off);
        logic [IW:0] s;
        s = {1'b0, base} + (IW+1)'(off);
        if (s >= (IW+1)'(NREQ)) begin
            s = s - (IW+1)'(NREQ);
        end
        return s[IW-1:0];
    endfunction

    logic          vld_arr   [NREQ];
    logic          we_arr    [NREQ];
    logic          lane_arr  [NREQ];
    logic [AW-1:0] addr_arr  [NREQ];
    logic [DW-1:0] wdata_arr [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign vld_arr[i]   = bus.req_valid[i];
        assign we_arr[i]    = bus.req_we[i];
        assign lane_arr[i]  = bus.req_sel[i];
        assign addr_arr[i]  = bus.req_addr[i*AW +: AW];
        assign wdata_arr[i] = bus.req_wdata[i*DW +: DW];
    end

    logic [IW-1:0]   ptr_q, ptr_d;
    logic            cen_q, cen_d;
    logic            wen_q, wen_d;
    logic            sel_q, sel_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic            s1_v_q, s1_v_d;
    logic [IW-1:0]   s1_id_q, s1_id_d;
    logic            s2_v_q, s2_v_d;
    logic [IW-1:0]   s2_id_q, s2_id_d;
    logic [2*DW-1:0] rdata_q, rdata_d;

    logic            gnt_any;
    logic [IW-1:0]   gnt_idx;

    // First valid requester at or above the pointer wins; nothing is granted during reset.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && vld_arr[wrap_idx(ptr_q, k)]) begin
                gnt_any = 1'b1;
                gnt_idx = wrap_idx(ptr_q, k);
            end
        end
        if (rst) begin
            gnt_any = 1'b0;
        end
    end

    assign bus.req_ready = gnt_any ? (NREQ'(1) << gnt_idx) : '0;

    always_comb begin
        ptr_d   = ptr_q;
        cen_d   = 1'b1;
        wen_d   = 1'b1;
        sel_d   = sel_q;
        addr_d  = addr_q;
        din_d   = din_q;
        s1_v_d  = 1'b0;
        s1_id_d = s1_id_q;
        s2_v_d  = s1_v_q;
        s2_id_d = s1_id_q;
        rdata_d = rdata_q;
        if (gnt_any) begin
            ptr_d   = wrap_idx(gnt_idx, 1);
            cen_d   = 1'b0;
            wen_d   = ~we_arr[gnt_idx];
            sel_d   = we_arr[gnt_idx] & lane_arr[gnt_idx];
            addr_d  = addr_arr[gnt_idx];
            din_d   = wdata_arr[gnt_idx];
            s1_v_d  = ~we_arr[gnt_idx];
            s1_id_d = gnt_idx;
        end
        // The SRAM word appears the cycle after its access edge, i.e. while stage 2 is valid.
        if (s2_v_q) begin
            rdata_d = sram_dout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cen_q   <= 1'b1;
            wen_q   <= 1'b1;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            s1_v_q  <= 1'b0;
            s1_id_q <= '0;
            s2_v_q  <= 1'b0;
            s2_id_q <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            cen_q   <= cen_d;
            wen_q   <= wen_d;
            sel_q   <= sel_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            s1_v_q  <= s1_v_d;
            s1_id_q <= s1_id_d;
            s2_v_q  <= s2_v_d;
            s2_id_q <= s2_id_d;
            rdata_q <= rdata_d;
        end
    end

    assign sram_cen      = cen_q;
    assign sram_wen      = wen_q;
    assign sram_sel      = sel_q;
    assign sram_addr     = addr_q;
    assign sram_din      = din_q;
    assign bus.rsp_valid = s2_v_q ? (NREQ'(1) << s2_id_q) : '0;
    assign bus.rsp_rdata = rdata_q;
    assign bus.busy      = s1_v_q | s2_v_q;
endmodule
